apa102_frame_tx: RTL and testbench

- Read-side consumer of the LED frame double buffer.
- On each frame-valid pulse, walks the read port of the double buffer and serialises one APA102-style frame onto the SPI LED strip: start frame, per-LED header+B+G+R, end frame.
- Sits between the double buffer read port and the top-level SPI pins.

---
 rtl/apa102_pkg.sv | 7 +
 rtl/apa102_frame_tx_shifter.sv | 51 +++++
 rtl/apa102_frame_tx.sv | 142 ++++++++++++++
 tb/tb_apa102_frame_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apa102_pkg.sv
// apa102_pkg: shared states and frame constants for the APA102 frame transmitter
package apa102_pkg;
  typedef enum logic [2:0] {IDLE, START, LED_HDR, LED_B, LED_G, LED_R, END} state_t;
  localparam int START_BYTES = 4;
  localparam logic [2:0] HDR_PREFIX = 3'b111;
  localparam logic [7:0] END_BYTE = 8'hFF;
endpackage

// File: rtl/apa102_frame_tx_shifter.sv
// spi_byte_shifter: mode-0 SPI byte serialiser with SCLK divider, MSB first
module spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_byte_done
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  logic [7:0]    r_sr;
  logic [DW-1:0] r_div;
  logic [2:0]    r_bit;
  logic          r_sclk;
  logic          r_active;
  logic          w_tick;
  assign w_tick      = r_active && r_div == DIV_MAX;
  assign o_byte_done = w_tick && r_sclk && r_bit == 3'd7;
  assign o_sclk      = r_sclk;
  assign o_mosi      = r_sr[7];
  // Shifting at the end of each high phase keeps MOSI changes inside the low phase
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sr     <= '0;
      r_div    <= '0;
      r_bit    <= '0;
      r_sclk   <= 1'b0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_sr     <= i_byte;
      r_div    <= '0;
      r_bit    <= '0;
      r_sclk   <= 1'b0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_sclk <= !r_sclk;
        if (r_sclk) begin
          r_sr     <= r_sr << 1;
          r_bit    <= r_bit + 1'b1;
          r_active <= r_bit != 3'd7;
        end
      end
    end
  end
endmodule

// File: rtl/apa102_frame_tx.sv
// apa102_frame_tx: reads one LED frame from the double buffer and shifts it out as an APA102 stream
module apa102_frame_tx
  import apa102_pkg::*;
#(
  parameter int LEDS       = 30,
  parameter int ADDR_WIDTH = $clog2(LEDS * 3),
  parameter int CLK_DIV    = 4,
  parameter int END_BYTES  = (LEDS + 15) / 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_frame_valid,
  input  logic [4:0]            i_brightness,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [7:0]            i_rd_data,
  output logic                  o_spi_sclk,
  output logic                  o_spi_mosi,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_overrun
);
  localparam int CMAX = START_BYTES > END_BYTES ? START_BYTES : END_BYTES;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int LW   = LEDS > 1 ? $clog2(LEDS) : 1;
  state_t                r_state, w_state_n;
  logic [LW-1:0]         r_led, w_led_n;
  logic [CW-1:0]         r_cnt, w_cnt_n;
  logic [ADDR_WIDTH-1:0] r_base, w_base_n, r_rd_addr, w_addr_n;
  logic [4:0]            r_bright;
  logic                  r_pending, r_done, r_overrun;
  logic                  w_load, w_byte_done, w_done_n, w_start, w_busy;
  logic [7:0]            w_byte;
  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_load),
    .i_byte      (w_byte),
    .o_sclk      (o_spi_sclk),
    .o_mosi      (o_spi_mosi),
    .o_byte_done (w_byte_done)
  );
  assign w_busy       = r_state != IDLE;
  assign w_start      = !w_busy && (i_frame_valid || r_pending);
  assign o_busy       = w_busy;
  assign o_rd_addr    = r_rd_addr;
  assign o_frame_done = r_done;
  assign o_overrun    = r_overrun;
  // r_base tracks 3*LED index; the read address is staged one byte ahead of its capture
  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_byte    = 8'h00;
    w_led_n   = r_led;
    w_cnt_n   = r_cnt;
    w_base_n  = r_base;
    w_addr_n  = r_rd_addr;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: if (w_start) begin
        w_state_n = START;
        w_load    = 1'b1;
        w_cnt_n   = '0;
        w_led_n   = '0;
        w_base_n  = '0;
      end
      START: if (w_byte_done) begin
        w_load = 1'b1;
        if (r_cnt == CW'(START_BYTES - 1)) begin
          w_state_n = LED_HDR;
          w_byte    = {HDR_PREFIX, r_bright};
          w_addr_n  = r_base + ADDR_WIDTH'(2);
        end else
          w_cnt_n = r_cnt + 1'b1;
      end
      LED_HDR: if (w_byte_done) begin
        w_load    = 1'b1;
        w_byte    = i_rd_data;
        w_state_n = LED_B;
        w_addr_n  = r_base + ADDR_WIDTH'(1);
      end
      LED_B: if (w_byte_done) begin
        w_load    = 1'b1;
        w_byte    = i_rd_data;
        w_state_n = LED_G;
        w_addr_n  = r_base;
      end
      LED_G: if (w_byte_done) begin
        w_load    = 1'b1;
        w_byte    = i_rd_data;
        w_state_n = LED_R;
      end
      LED_R: if (w_byte_done) begin
        w_load = 1'b1;
        if (r_led == LW'(LEDS - 1)) begin
          w_state_n = END;
          w_byte    = END_BYTE;
          w_cnt_n   = '0;
        end else begin
          w_state_n = LED_HDR;
          w_byte    = {HDR_PREFIX, r_bright};
          w_led_n   = r_led + 1'b1;
          w_base_n  = r_base + ADDR_WIDTH'(3);
          w_addr_n  = r_base + ADDR_WIDTH'(5);
        end
      end
      END: if (w_byte_done) begin
        if (r_cnt == CW'(END_BYTES - 1)) begin
          w_state_n = IDLE;
          w_done_n  = 1'b1;
        end else begin
          w_load  = 1'b1;
          w_byte  = END_BYTE;
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_led     <= '0;
      r_cnt     <= '0;
      r_base    <= '0;
      r_rd_addr <= '0;
      r_bright  <= '0;
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_led     <= w_led_n;
      r_cnt     <= w_cnt_n;
      r_base    <= w_base_n;
      r_rd_addr <= w_addr_n;
      r_bright  <= w_start ? i_brightness : r_bright;
      r_done    <= w_done_n;
      r_overrun <= w_busy && i_frame_valid && r_pending;
      r_pending <= w_start ? r_pending && i_frame_valid : r_pending || (w_busy && i_frame_valid);
    end
  end
endmodule

// File: tb/tb_apa102_frame_tx.sv
// tb_apa102_frame_tx: randomized self-checking bench against a byte-level frame model
module tb_apa102_frame_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [4:0] bright = 5'd0;
  logic [2:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic       sclk_a, mosi_a, busy_a, done_p_a, ovr_p_a;
  logic       sclk_b, mosi_b, busy_b, done_p_b, ovr_p_b;
  logic [7:0] mem [0:5];
  logic [7:0] exp_q [$];
  logic [7:0] got_a [$];
  logic [7:0] got_b [$];
  int         busy_lens_a [$];
  int         busy_lens_b [$];
  int         gaps_a [$];
  int         checks = 0, errors = 0;
  int         done_a, ovr_a, done_b, unstable_b;
  int         nb_a, nb_b, busy_run_a, busy_run_b, idle_run_a;
  logic [7:0] acc_a, acc_b;
  logic       ps_a, pb_a, ps_b, pb_b, pm_b;
  logic       clr = 1'b0;

  always #5 clk = !clk;
  assign data_a = addr_a < 3'd6 ? mem[addr_a] : 8'h00;
  assign data_b = addr_b < 3'd6 ? mem[addr_b] : 8'h00;

  apa102_frame_tx #(.LEDS(2), .CLK_DIV(2), .END_BYTES(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_valid(valid), .i_brightness(bright),
    .o_rd_addr(addr_a), .i_rd_data(data_a), .o_spi_sclk(sclk_a), .o_spi_mosi(mosi_a),
    .o_busy(busy_a), .o_frame_done(done_p_a), .o_overrun(ovr_p_a));
  apa102_frame_tx #(.LEDS(2), .CLK_DIV(1), .END_BYTES(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_valid(valid), .i_brightness(bright),
    .o_rd_addr(addr_b), .i_rd_data(data_b), .o_spi_sclk(sclk_b), .o_spi_mosi(mosi_b),
    .o_busy(busy_b), .o_frame_done(done_p_b), .o_overrun(ovr_p_b));

  // Line monitors: bytes assembled from MOSI at SCLK rises, busy run lengths, idle gaps
  always @(negedge clk) begin
    if (clr) begin
      got_a.delete(); got_b.delete(); busy_lens_a.delete(); busy_lens_b.delete(); gaps_a.delete();
      nb_a = 0; nb_b = 0; done_a = 0; done_b = 0; ovr_a = 0; unstable_b = 0;
      busy_run_a = 0; busy_run_b = 0; idle_run_a = 0;
    end else begin
      if (sclk_a && !ps_a) begin
        acc_a = {acc_a[6:0], mosi_a};
        nb_a++;
        if (nb_a == 8) begin got_a.push_back(acc_a); nb_a = 0; end
      end
      if (sclk_b && !ps_b) begin
        acc_b = {acc_b[6:0], mosi_b};
        nb_b++;
        if (mosi_b !== pm_b) unstable_b++;
        if (nb_b == 8) begin got_b.push_back(acc_b); nb_b = 0; end
      end
      if (busy_a) busy_run_a++;
      else if (pb_a) begin busy_lens_a.push_back(busy_run_a); busy_run_a = 0; end
      if (!busy_a) idle_run_a++;
      else if (!pb_a) begin gaps_a.push_back(idle_run_a); idle_run_a = 0; end
      if (busy_b) busy_run_b++;
      else if (pb_b) begin busy_lens_b.push_back(busy_run_b); busy_run_b = 0; end
      if (done_p_a) done_a++;
      if (done_p_b) done_b++;
      if (ovr_p_a) ovr_a++;
    end
    ps_a = sclk_a; pb_a = busy_a; ps_b = sclk_b; pb_b = busy_b; pm_b = mosi_b;
  end

  // Reference frame: 4 zero bytes, then per LED {111,brightness},B,G,R, then 0xFF
  task automatic build_exp(input logic [4:0] b);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back({3'b111, b});
      exp_q.push_back(mem[3*n+2]);
      exp_q.push_back(mem[3*n+1]);
      exp_q.push_back(mem[3*n]);
    end
    exp_q.push_back(8'hFF);
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse();
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 4000; i++) begin
      if (done_a >= n) break;
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (sclk_a !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk_a); end
    if (mosi_a !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi_a); end
    if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    if (done_p_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_p_a); end
    if (ovr_p_a !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", ovr_p_a); end
    if (addr_a !== 3'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr_a); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[4] = 8'h55; mem[5] = 8'h66;
    bright = 5'd31;
    clear_mon();
    build_exp(5'd31);
    pulse();
    wait_done(1);
    checks += 7;
    if (done_a != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_a); end
    if (busy_lens_a.size() != 1 || busy_lens_a[0] != 416) begin errors++; $display("FAIL single_busy_len: got %0d runs first %0d expected 416", busy_lens_a.size(), busy_lens_a.size() ? busy_lens_a[0] : -1); end
    if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL single_len: got %0d expected %0d", got_a.size(), exp_q.size()); end
    if (ovr_a != 0) begin errors++; $display("FAIL single_overrun: got %0d expected 0", ovr_a); end
    if (done_b != 1) begin errors++; $display("FAIL div1_done_count: got %0d expected 1", done_b); end
    if (busy_lens_b.size() != 1 || busy_lens_b[0] != 208) begin errors++; $display("FAIL div1_busy_len: got %0d runs first %0d expected 208", busy_lens_b.size(), busy_lens_b.size() ? busy_lens_b[0] : -1); end
    if (unstable_b != 0) begin errors++; $display("FAIL div1_mosi_stable: got %0d changes at SCLK rise expected 0", unstable_b); end
    foreach (exp_q[i]) begin
      checks += 2;
      if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d: got %0h expected %0h", i, i < got_a.size() ? got_a[i] : 8'hxx, exp_q[i]); end
      if (i >= got_b.size() || got_b[i] !== exp_q[i]) begin errors++; $display("FAIL div1_byte%0d: got %0h expected %0h", i, i < got_b.size() ? got_b[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_brightness();
    bright = 5'd3;
    clear_mon();
    build_exp(5'd3);
    pulse();
    repeat (100) @(posedge clk);
    #1;
    bright = 5'd0;
    wait_done(1);
    checks++;
    if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL bright_len: got %0d expected %0d", got_a.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin errors++; $display("FAIL bright_byte%0d: got %0h expected %0h", i, i < got_a.size() ? got_a[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 6; k++) mem[k] = 8'($urandom);
      bright = 5'($urandom);
      clear_mon();
      build_exp(bright);
      pulse();
      wait_done(1);
      checks++;
      if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_len: got %0d expected %0d", t, got_a.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        checks++;
        if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_byte%0d: got %0h expected %0h", t, i, i < got_a.size() ? got_a[i] : 8'hxx, exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bright = 5'($urandom);
    clear_mon();
    build_exp(bright);
    build_exp(bright);
    pulse();
    repeat (150) @(posedge clk);
    #1;
    pulse();
    wait_done(2);
    checks += 5;
    if (done_a != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_a); end
    if (ovr_a != 0) begin errors++; $display("FAIL b2b_overrun: got %0d expected 0", ovr_a); end
    if (gaps_a.size() != 2 || gaps_a[1] != 1) begin errors++; $display("FAIL b2b_gap: got %0d gaps last %0d expected 1", gaps_a.size(), gaps_a.size() ? gaps_a[gaps_a.size()-1] : -1); end
    if (busy_lens_a.size() != 2 || busy_lens_a[1] != 416) begin errors++; $display("FAIL b2b_busy_len: got %0d runs expected 2 of 416", busy_lens_a.size()); end
    if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len: got %0d expected %0d", got_a.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %0h expected %0h", i, i < got_a.size() ? got_a[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  task automatic test_overrun();
    clear_mon();
    pulse();
    repeat (50) @(posedge clk);
    #1;
    pulse();
    repeat (50) @(posedge clk);
    #1;
    pulse();
    wait_done(2);
    repeat (600) @(posedge clk);
    #1;
    checks += 3;
    if (ovr_a != 1) begin errors++; $display("FAIL ovr_count: got %0d expected 1", ovr_a); end
    if (done_a != 2) begin errors++; $display("FAIL ovr_frames: got %0d expected 2", done_a); end
    if (got_a.size() != 26) begin errors++; $display("FAIL ovr_bytes: got %0d expected 26", got_a.size()); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) mem[k] = 8'($urandom);
    bright = 5'd17;
    clear_mon();
    pulse();
    repeat (200) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks += 3;
    if (sclk_a !== 1'b0) begin errors++; $display("FAIL midrst_sclk: got %b expected 0", sclk_a); end
    if (mosi_a !== 1'b0) begin errors++; $display("FAIL midrst_mosi: got %b expected 0", mosi_a); end
    if (busy_a !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    checks++;
    if (done_a != 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", done_a); end
    clear_mon();
    build_exp(5'd17);
    pulse();
    wait_done(1);
    checks += 2;
    if (done_a != 1) begin errors++; $display("FAIL midrst_fresh_done: got %0d expected 1", done_a); end
    if (got_a.size() != exp_q.size()) begin errors++; $display("FAIL midrst_len: got %0d expected %0d", got_a.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_byte%0d: got %0h expected %0h", i, i < got_a.size() ? got_a[i] : 8'hxx, exp_q[i]); end
    end
  endtask

  initial begin
    for (int k = 0; k < 6; k++) mem[k] = 8'h00;
    test_reset();
    test_single_frame();
    test_brightness();
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
